// File: rtl/lamp_decoder.sv
// rtl/lamp_decoder.sv - letter code to one-hot lamp sequencer with hold and dark gap
module lamp_decoder #(
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [4:0]  LET,
  input  logic        LET_VALID,
  input  logic        CLEAR,
  output logic        LET_READY,
  output logic [25:0] LAMP,
  output logic        BUSY,
  output logic        ERR
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t       r_state;
  logic [15:0]  r_cnt;
  logic [25:0]  r_lamp;
  logic         r_err;
  logic         w_take;

  assign LET_READY = (r_state == IDLE) & ~CLEAR & ~RST;
  assign w_take    = LET_VALID & LET_READY;
  assign LAMP      = r_lamp;
  assign BUSY      = (r_state != IDLE);
  assign ERR       = r_err;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_cnt   <= 16'd0;
      r_lamp  <= 26'd0;
      r_err   <= 1'b0;
    end else if (CLEAR) begin
      r_state <= IDLE;
      r_cnt   <= 16'd0;
      r_lamp  <= 26'd0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_take) begin
            if (LET <= 5'd25) begin
              r_state <= SHOW;
              r_lamp  <= 26'd1 << LET;
              r_cnt   <= 16'(HOLD_CYCLES - 1);
            end else begin
              // out-of-range code is consumed; only the error pulse remains
              r_err <= 1'b1;
            end
          end
        end
        SHOW: begin
          if (r_cnt != 16'd0) begin
            r_cnt <= r_cnt - 16'd1;
          end else begin
            r_lamp <= 26'd0;
            if (GAP_CYCLES == 0) begin
              r_state <= IDLE;
            end else begin
              r_state <= GAP;
              r_cnt   <= 16'(GAP_CYCLES - 1);
            end
          end
        end
        GAP: begin
          r_lamp <= 26'd0;
          if (r_cnt != 16'd0) begin
            r_cnt <= r_cnt - 16'd1;
          end else begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= 16'd0;
          r_lamp  <= 26'd0;
        end
      endcase
    end
  end

endmodule
